// File: rtl/acc_flag_writeback_if.sv
// acc_flag_writeback_if: bundles the ALU-result handshake, the architectural
// outputs and the store-path handshake of the writeback stage.
//   slave  : the writeback stage (consumes ALU result, produces acc/flags/store)
//   master : upstream ALU / memory side (drives ALU result and st_ready)
interface acc_flag_writeback_if #(
  parameter int WIDTH = 16
);
  // ALU -> stage
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;
  logic             alu_overflow;
  logic             alu_gt;
  logic             alu_lt;
  logic             wr_acc;
  logic             wr_flags;
  logic             wr_mem;
  logic [2:0]       br_cond;
  // architectural state
  logic [WIDTH-1:0] acc;
  logic [3:0]       flags;     // {OV, LT, GT, Z}
  logic             br_taken;
  // store path
  logic             st_valid;
  logic [WIDTH-1:0] st_data;
  logic             st_ready;

  modport slave (
    input  in_valid, alu_out, alu_zero, alu_overflow, alu_gt, alu_lt,
           wr_acc, wr_flags, wr_mem, br_cond, st_ready,
    output in_ready, acc, flags, br_taken, st_valid, st_data
  );

  modport master (
    output in_valid, alu_out, alu_zero, alu_overflow, alu_gt, alu_lt,
           wr_acc, wr_flags, wr_mem, br_cond, st_ready,
    input  in_ready, acc, flags, br_taken, st_valid, st_data
  );
endinterface

// File: rtl/acc_flag_writeback.sv
// acc_flag_writeback: writeback stage behind the 16-bit ALU.
// Captures the ALU result into the accumulator, latches status flags,
// resolves conditional branches and forwards stores through a one-entry
// valid/ready buffer. All outputs registered except in_ready.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high
//   bus   - acc_flag_writeback_if.slave (ALU input, acc/flags/br_taken, store)
module acc_flag_writeback #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  acc_flag_writeback_if.slave   bus
);

  localparam logic [2:0] BR_NONE0 = 3'b000;
  localparam logic [2:0] BR_Z     = 3'b001;
  localparam logic [2:0] BR_NZ    = 3'b010;
  localparam logic [2:0] BR_GT    = 3'b011;
  localparam logic [2:0] BR_LT    = 3'b100;
  localparam logic [2:0] BR_OV    = 3'b101;
  localparam logic [2:0] BR_ALW   = 3'b110;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [3:0]       flags_q, flags_d;
  logic             br_q, br_d;
  logic             st_valid_q, st_valid_d;
  logic [WIDTH-1:0] st_data_q, st_data_d;

  logic       in_ready;
  logic       accept;
  logic [3:0] in_flags;
  logic [3:0] eff_flags;
  logic       cond_true;

  // Whole stage stalls on a full, non-draining store buffer so that
  // accumulator/flag updates never overtake an outstanding store.
  assign in_ready  = !(st_valid_q && !bus.st_ready);
  assign accept    = bus.in_valid && in_ready;
  assign in_flags  = {bus.alu_overflow, bus.alu_lt, bus.alu_gt, bus.alu_zero};
  // Branch sees this transaction's own flags when it writes them.
  assign eff_flags = bus.wr_flags ? in_flags : flags_q;

  always_comb begin
    cond_true = 1'b0;
    case (bus.br_cond)
      BR_Z:    cond_true = eff_flags[0];
      BR_NZ:   cond_true = !eff_flags[0];
      BR_GT:   cond_true = eff_flags[1];
      BR_LT:   cond_true = eff_flags[2];
      BR_OV:   cond_true = eff_flags[3];
      BR_ALW:  cond_true = 1'b1;
      BR_NONE0: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    acc_d      = acc_q;
    flags_d    = flags_q;
    br_d       = accept && cond_true;
    st_valid_d = st_valid_q;
    st_data_d  = st_data_q;
    if (accept && bus.wr_acc)   acc_d   = bus.alu_out;
    if (accept && bus.wr_flags) flags_d = in_flags;
    // Refill wins over drain: a simultaneous drain+push keeps st_valid high.
    if (accept && bus.wr_mem) begin
      st_valid_d = 1'b1;
      st_data_d  = bus.alu_out;
    end else if (st_valid_q && bus.st_ready) begin
      st_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q      <= '0;
      flags_q    <= '0;
      br_q       <= 1'b0;
      st_valid_q <= 1'b0;
      st_data_q  <= '0;
    end else begin
      acc_q      <= acc_d;
      flags_q    <= flags_d;
      br_q       <= br_d;
      st_valid_q <= st_valid_d;
      st_data_q  <= st_data_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.acc      = acc_q;
  assign bus.flags    = flags_q;
  assign bus.br_taken = br_q;
  assign bus.st_valid = st_valid_q;
  assign bus.st_data  = st_data_q;

endmodule

// File: tb/tb_acc_flag_writeback.sv
module tb_acc_flag_writeback;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  acc_flag_writeback_if #(.WIDTH(W)) bus();
  acc_flag_writeback #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: accumulator, flag nibble, a store queue of depth <= 1,
  // and the last value pushed (what st_data shows).
  logic [W-1:0] m_acc;
  logic [3:0]   m_flags;
  logic         m_br;
  logic [W-1:0] m_st_data;
  logic [W-1:0] st_q[$];
  bit           m_known = 0;

  function automatic bit br_rule(input logic [2:0] c, input logic z, input logic gt,
                                 input logic lt, input logic ov);
    if (c == 3'd1) return z;
    if (c == 3'd2) return !z;
    if (c == 3'd3) return gt;
    if (c == 3'd4) return lt;
    if (c == 3'd5) return ov;
    if (c == 3'd6) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_ready();
    return (st_q.size() == 0) || bus.st_ready;
  endfunction

  task automatic model_step();
    bit           take;
    logic         z, gt, lt, ov;
    if (reset) begin
      m_acc = '0; m_flags = '0; m_br = 0; m_st_data = '0; st_q.delete();
      m_known = 1;
      return;
    end
    take = bus.in_valid && m_ready();
    if (bus.wr_flags) begin
      z = bus.alu_zero; gt = bus.alu_gt; lt = bus.alu_lt; ov = bus.alu_overflow;
    end else begin
      z = m_flags[0]; gt = m_flags[1]; lt = m_flags[2]; ov = m_flags[3];
    end
    m_br = take && br_rule(bus.br_cond, z, gt, lt, ov);
    if (st_q.size() != 0 && bus.st_ready) void'(st_q.pop_front());
    if (take && bus.wr_mem) begin
      st_q.push_back(bus.alu_out);
      m_st_data = bus.alu_out;
    end
    if (take && bus.wr_acc) m_acc = bus.alu_out;
    if (take && bus.wr_flags)
      m_flags = {bus.alu_overflow, bus.alu_lt, bus.alu_gt, bus.alu_zero};
  endtask

  // One clock: check combinational ready mid-cycle, then registered outputs after the edge.
  task automatic cycle();
    @(negedge clk);
    if (m_known) chk("in_ready", bus.in_ready, m_ready());
    @(posedge clk);
    model_step();
    #1;
    chk("acc",      bus.acc,      m_acc);
    chk("flags",    bus.flags,    m_flags);
    chk("br_taken", bus.br_taken, m_br);
    chk("st_valid", bus.st_valid, st_q.size() != 0);
    chk("st_data",  bus.st_data,  m_st_data);
  endtask

  task automatic set_in(input logic v, input logic [W-1:0] d, input logic z, input logic ov,
                        input logic gt, input logic lt, input logic wa, input logic wf,
                        input logic wm, input logic [2:0] c, input logic sr);
    bus.in_valid = v;  bus.alu_out = d;
    bus.alu_zero = z;  bus.alu_overflow = ov; bus.alu_gt = gt; bus.alu_lt = lt;
    bus.wr_acc = wa;   bus.wr_flags = wf;     bus.wr_mem = wm;
    bus.br_cond = c;   bus.st_ready = sr;
  endtask

  initial begin
    // Reset with a live transaction that must be discarded.
    reset = 1'b1;
    set_in(1, 16'h1234, 0,0,0,0, 1,0,0, 3'b000, 1);
    cycle();
    reset = 1'b0;
    chk("rst_acc", bus.acc, 16'h0000);
    chk("rst_flags", bus.flags, 4'h0);
    chk("rst_in_ready", bus.in_ready, 1'b1);

    // Flag write with bypass branch on Z.
    set_in(1, 16'h0000, 1,0,0,0, 1,1,0, 3'b001, 1); cycle();
    chk("bypass_flags", bus.flags, 4'b0001);
    chk("bypass_br", bus.br_taken, 1'b1);
    set_in(0, 16'h0000, 0,0,0,0, 0,0,0, 3'b000, 1); cycle();
    chk("br_pulse_end", bus.br_taken, 1'b0);

    // Stored flags only.
    set_in(1, 16'h0000, 0,0,1,0, 0,1,0, 3'b000, 1); cycle();
    set_in(1, 16'h0000, 0,0,0,0, 0,0,0, 3'b011, 1); cycle();
    chk("stored_gt", bus.br_taken, 1'b1);
    set_in(1, 16'h0000, 0,0,0,0, 0,0,0, 3'b100, 1); cycle();
    chk("stored_lt", bus.br_taken, 1'b0);

    // Store backpressure.
    set_in(1, 16'hBEEF, 0,0,0,0, 0,0,1, 3'b000, 0); cycle();
    chk("bp_st_data", bus.st_data, 16'hBEEF);
    chk("bp_in_ready", bus.in_ready, 1'b0);
    set_in(1, 16'h0001, 0,0,0,0, 1,0,0, 3'b000, 0);
    repeat (3) cycle();
    chk("bp_acc_held", bus.acc, 16'h0000);
    chk("bp_data_held", bus.st_data, 16'hBEEF);
    set_in(1, 16'h0001, 0,0,0,0, 1,0,0, 3'b000, 1); cycle();
    chk("bp_release_acc", bus.acc, 16'h0001);
    chk("bp_release_st", bus.st_valid, 1'b0);

    // Drain and refill.
    set_in(1, 16'h1111, 0,0,0,0, 0,0,1, 3'b000, 1); cycle();
    set_in(1, 16'h00A5, 0,0,0,0, 0,0,1, 3'b000, 1); cycle();
    chk("refill_valid", bus.st_valid, 1'b1);
    chk("refill_data", bus.st_data, 16'h00A5);
    set_in(0, 16'h0000, 0,0,0,0, 0,0,0, 3'b000, 1); cycle();
    chk("drain_valid", bus.st_valid, 1'b0);

    // No-branch code, always, back-to-back pulses, max value.
    set_in(1, 16'h0000, 1,1,1,1, 0,1,0, 3'b111, 1); cycle();
    chk("br_111", bus.br_taken, 1'b0);
    set_in(1, 16'h0000, 1,1,1,1, 0,1,0, 3'b110, 1); cycle();
    chk("br_110", bus.br_taken, 1'b1);
    cycle();
    chk("br_110_again", bus.br_taken, 1'b1);
    set_in(1, 16'hFFFF, 0,0,0,0, 1,0,0, 3'b000, 1); cycle();
    chk("acc_max", bus.acc, 16'hFFFF);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      set_in($urandom_range(0, 3) != 0, W'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom),
             3'($urandom), $urandom_range(0, 9) < 6);
      cycle();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
